// File: rtl/vfd_speed_ramp_ctrl.sv
// vfd_speed_ramp_ctrl: slews the VFD drive-clock divider reload between a
// stop speed (DIV_MAX) and a clamped target. It also sequences start, stop
// and reversal so that clk_out never jumps in frequency and always parks low.
// Ports:
//   clk_in, reset (async, active-high)
//   run, dir_in, target_div, ramp_period       -> command inputs
//   clk_out, tick, dir_out, cur_div, state, at_speed -> registered outputs
module vfd_speed_ramp_ctrl #(
  parameter int DIV_W   = 13,
  parameter int DIV_MIN = 294,
  parameter int DIV_MAX = 4095,
  parameter int RAMP_W  = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              run,
  input  logic              dir_in,
  input  logic [DIV_W-1:0]  target_div,
  input  logic [RAMP_W-1:0] ramp_period,
  output logic              clk_out,
  output logic              tick,
  output logic              dir_out,
  output logic [DIV_W-1:0]  cur_div,
  output logic [1:0]        state,
  output logic              at_speed
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SLEW  = 2'd1,
    S_RUN   = 2'd2,
    S_DECEL = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] L_MIN = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] L_MAX = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] L_ONE = DIV_W'(1);

  state_t              r_state;
  logic                r_clk_out;
  logic                r_tick;
  logic                r_dir;
  logic                r_at_speed;
  logic [DIV_W-1:0]    r_cur_div;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [RAMP_W-1:0]   r_ramp_cnt;

  logic [DIV_W-1:0]    w_tgt;
  logic                w_active;
  logic                w_step;
  logic                w_toggle;
  logic                w_stop;

  always_comb begin
    w_tgt = target_div;
    if (target_div < L_MIN)
      w_tgt = L_MIN;
    else if (target_div > L_MAX)
      w_tgt = L_MAX;
    w_active = (r_state != S_IDLE);
    // >= tolerates ramp_period being lowered under the running count
    w_step   = w_active && (r_ramp_cnt >= ramp_period);
    // >= absorbs cur_div shrinking below the running count
    w_toggle = w_active && (r_div_cnt >= r_cur_div);
    w_stop   = !run || (dir_in != r_dir);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_clk_out  <= 1'b0;
      r_tick     <= 1'b0;
      r_dir      <= 1'b0;
      r_at_speed <= 1'b0;
      r_cur_div  <= L_MAX;
      r_div_cnt  <= '0;
      r_ramp_cnt <= '0;
    end else begin
      r_tick <= 1'b0;
      if (w_active) begin
        if (w_step)
          r_ramp_cnt <= '0;
        else
          r_ramp_cnt <= r_ramp_cnt + 1'b1;
        if (w_toggle) begin
          r_div_cnt <= '0;
          r_clk_out <= ~r_clk_out;
          r_tick    <= 1'b1;
        end else begin
          r_div_cnt <= r_div_cnt + L_ONE;
        end
      end
      unique case (r_state)
        S_IDLE: begin
          r_ramp_cnt <= '0;
          r_div_cnt  <= '0;
          r_clk_out  <= 1'b0;
          r_cur_div  <= L_MAX;
          if (run) begin
            r_state <= S_SLEW;
            r_dir   <= dir_in;
          end
        end
        S_SLEW: begin
          if (w_stop) begin
            r_state <= S_DECEL;
          end else if (w_step && (r_cur_div != w_tgt)) begin
            if (r_cur_div > w_tgt)
              r_cur_div <= r_cur_div - L_ONE;
            else
              r_cur_div <= r_cur_div + L_ONE;
          end else if (r_cur_div == w_tgt) begin
            r_state    <= S_RUN;
            r_at_speed <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_stop) begin
            r_state    <= S_DECEL;
            r_at_speed <= 1'b0;
          end else if (w_tgt != r_cur_div) begin
            r_state    <= S_SLEW;
            r_at_speed <= 1'b0;
          end
        end
        S_DECEL: begin
          if (run && (dir_in == r_dir)) begin
            r_state <= S_SLEW;
          end else begin
            if (w_step && (r_cur_div != L_MAX))
              r_cur_div <= r_cur_div + L_ONE;
            // park only on a falling toggle at stop speed
            if ((r_cur_div == L_MAX) && w_toggle && r_clk_out) begin
              r_state    <= S_IDLE;
              r_div_cnt  <= '0;
              r_ramp_cnt <= '0;
            end
          end
        end
      endcase
    end
  end

  assign clk_out  = r_clk_out;
  assign tick     = r_tick;
  assign dir_out  = r_dir;
  assign cur_div  = r_cur_div;
  assign state    = r_state;
  assign at_speed = r_at_speed;

endmodule

// File: tb/tb_vfd_speed_ramp_ctrl.sv
// tb_vfd_speed_ramp_ctrl: directed bench for vfd_speed_ramp_ctrl
// with DIV_MIN=4, DIV_MAX=20.
module tb_vfd_speed_ramp_ctrl;

  logic        clk_in;
  logic        reset;
  logic        run;
  logic        dir_in;
  logic [12:0] target_div;
  logic [15:0] ramp_period;
  logic        clk_out;
  logic        tick;
  logic        dir_out;
  logic [12:0] cur_div;
  logic [1:0]  state;
  logic        at_speed;

  int checks = 0;
  int failures = 0;

  vfd_speed_ramp_ctrl #(
    .DIV_W(13), .DIV_MIN(4), .DIV_MAX(20), .RAMP_W(16)
  ) dut (
    .clk_in(clk_in), .reset(reset), .run(run), .dir_in(dir_in),
    .target_div(target_div), .ramp_period(ramp_period),
    .clk_out(clk_out), .tick(tick), .dir_out(dir_out),
    .cur_div(cur_div), .state(state), .at_speed(at_speed)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_state(input string tag,
                            input logic [1:0] s,
                            input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (state != s && n < bound);
    chk(tag, 32'(state == s), 1);
  endtask

  initial begin
    int n;
    int bad;
    logic [12:0] prev;
    logic pclk;

    reset = 1'b1;
    run = 1'b0;
    dir_in = 1'b0;
    target_div = 13'd4;
    ramp_period = 16'd0;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    chk("rst_clk", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_dir", dir_out, 0);
    chk("rst_div", cur_div, 20);
    chk("rst_state", state, 0);
    chk("rst_atspd", at_speed, 0);

    // start: 20 -> 4, one step per cycle
    run = 1'b1;
    @(negedge clk_in);
    chk("start_state", state, 1);
    chk("start_div", cur_div, 20);
    n = 0;
    bad = 0;
    do begin
      @(negedge clk_in);
      n++;
      if (cur_div != 13'(20 - n)) bad++;
    end while (cur_div != 13'd4 && n < 40);
    chk("slew_steps", n, 16);
    chk("slew_seq", bad, 0);
    @(negedge clk_in);
    chk("run_state", state, 2);
    chk("run_atspd", at_speed, 1);

    // half-period at cur_div=4
    n = 0;
    while (!tick && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    pclk = clk_out;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!tick && n < 20);
    chk("half_period", n, 5);
    chk("clk_toggled", clk_out, 32'(!pclk));

    // retarget to 10 at ramp_period=3
    target_div = 13'd10;
    ramp_period = 16'd3;
    @(negedge clk_in);
    chk("retgt_state", state, 1);
    chk("retgt_atspd", at_speed, 0);
    prev = cur_div;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (cur_div == prev && n < 10);
    prev = cur_div;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (cur_div == prev && n < 10);
    chk("step_spacing", n, 4);
    chk("slew_atspd", at_speed, 0);
    wait_state("retgt_run", 2'd2, 100);
    chk("retgt_div", cur_div, 10);
    chk("retgt_atspd1", at_speed, 1);

    // clamp low and high
    ramp_period = 16'd0;
    target_div = 13'd1;
    wait_state("clamp_lo_run", 2'd2, 60);
    chk("clamp_lo_div", cur_div, 4);
    target_div = 13'd4000;
    wait_state("clamp_hi_run", 2'd2, 60);
    chk("clamp_hi_div", cur_div, 20);
    target_div = 13'd4;
    wait_state("back4_run", 2'd2, 60);
    chk("back4_div", cur_div, 4);

    // stop: decel to 20, park low
    run = 1'b0;
    @(negedge clk_in);
    chk("stop_state", state, 3);
    chk("stop_atspd", at_speed, 0);
    n = 0;
    pclk = clk_out;
    while (state != 2'd0 && n < 300) begin
      pclk = clk_out;
      @(negedge clk_in);
      n++;
    end
    chk("stop_idle", state, 0);
    chk("stop_clk", clk_out, 0);
    chk("stop_prevclk", pclk, 1);
    chk("stop_tick", tick, 1);
    chk("stop_div", cur_div, 20);
    chk("stop_divcnt", dut.r_div_cnt, 0);
    chk("stop_rampcnt", dut.r_ramp_cnt, 0);

    // reversal
    run = 1'b1;
    wait_state("rev_run", 2'd2, 60);
    chk("rev_dir0", dir_out, 0);
    dir_in = 1'b1;
    @(negedge clk_in);
    chk("rev_decel", state, 3);
    chk("rev_dirhold", dir_out, 0);
    wait_state("rev_idle", 2'd0, 300);
    @(negedge clk_in);
    chk("rev_reslew", state, 1);
    chk("rev_dir1", dir_out, 1);

    // resume mid-decel, same direction
    wait_state("res_run", 2'd2, 60);
    run = 1'b0;
    repeat (5) @(negedge clk_in);
    chk("res_decel", state, 3);
    chk("res_decdiv", cur_div, 8);
    run = 1'b1;
    @(negedge clk_in);
    chk("res_slew", state, 1);
    chk("res_div", cur_div, 8);
    n = 0;
    bad = 0;
    do begin
      @(negedge clk_in);
      n++;
      if (state == 2'd0) bad++;
    end while (state != 2'd2 && n < 60);
    chk("res_noidle", bad, 0);
    chk("res_run2", state, 2);

    // async reset mid-RUN
    n = 0;
    while (!clk_out && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    chk("pre_rst_clk", clk_out, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_clk", clk_out, 0);
    chk("arst_div", cur_div, 20);
    chk("arst_state", state, 0);
    chk("arst_tick", tick, 0);
    chk("arst_atspd", at_speed, 0);
    @(negedge clk_in);
    reset = 1'b0;
    run = 1'b0;
    @(negedge clk_in);
    chk("post_rst", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vfd_speed_ramp_ctrl.md
# vfd_speed_ramp_ctrl

Speed sequencer for the VFD drive-clock divider. It owns the divider reload value and slews it between a stop speed and a commanded target at a programmable ramp rate. It emits the resulting drive clock and a per-toggle tick for the sine/PWM stage. It also sequences start, stop and direction reversal so the drive clock never jumps in frequency and always parks low.

## Interface
- DIV_W, 13: width of divider reload and counter.
- DIV_MIN, 294: smallest allowed reload (fastest speed).
- DIV_MAX, 4095: largest allowed reload (stop/start speed); DIV_MIN ≤ DIV_MAX ≤ 2^DIV_W−1.
- RAMP_W, 16: width of ramp prescaler.

- clk_in  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = drive running, 0 = decelerate to stop.
- dir_in  in  1  requested rotation direction.
- target_div  in  DIV_W  commanded reload; clamped to [DIV_MIN, DIV_MAX].
- ramp_period  in  RAMP_W  clk_in cycles per ramp step, minus 1 (0 = step every cycle).
- clk_out  out  1  drive clock, half-period = cur_div+1 cycles.
- tick  out  1  one-cycle pulse coincident with every clk_out toggle.
- dir_out  out  1  direction latched at start.
- cur_div  out  DIV_W  current reload value.
- state  out  2  IDLE=0, SLEW=1, RUN=2, DECEL=3.
- at_speed  out  1  high when state==RUN.

## Operation
- Reset values: clk_out=0, tick=0, dir_out=0, cur_div=DIV_MAX, state=IDLE, at_speed=0, divider counter=0, ramp counter=0.
- tgt = clamp(target_div, DIV_MIN, DIV_MAX), evaluated combinationally every cycle.
- Ramp prescaler:
  - Runs only outside IDLE.
  - Counts 0..ramp_period, then wraps to 0.
  - Asserts an internal ramp_step in the wrap cycle.
  - Restarts at 0 when the state leaves IDLE.
- Divider:
  - Runs only outside IDLE.
  - When counter ≥ cur_div: counter←0, clk_out toggles, tick=1. Otherwise counter+1.
  - The ≥ compare absorbs cur_div decreasing below the counter.
  - A changed cur_div takes effect at the next compare.
- States:
  - IDLE: counters held at 0, clk_out=0, cur_div=DIV_MAX. run=1 → SLEW, dir_out←dir_in.
  - SLEW: on each ramp_step, cur_div moves one count toward tgt; ±1 only, never overshoots.
    - cur_div==tgt → RUN.
    - run=0 → DECEL.
    - dir_in≠dir_out → DECEL.
  - RUN: tgt≠cur_div → SLEW. run=0 or dir_in≠dir_out → DECEL.
  - DECEL: on each ramp_step, cur_div+1 saturating at DIV_MAX.
    - run=1 and dir_in==dir_out → SLEW, from current cur_div.
    - cur_div==DIV_MAX and a toggle drives clk_out to 0 → IDLE.
- Reversal: DECEL reaches IDLE, dwells exactly 1 cycle, then re-enters SLEW with the new dir_out if run is still 1.
- Priority within a cycle: stop/reversal > slew step > RUN entry.
- A tgt change and a ramp_step in the same cycle use the new tgt.
- reset mid-operation: all outputs return to reset values immediately, asynchronously. The clk_out glitch is acceptable.

## Timing
- run sampled high at edge N → state=SLEW after edge N. Divider counts from that cycle. First tick after cur_div+1 cycles in SLEW.
- tick and clk_out update on the same edge; tick is registered, high exactly 1 cycle.
- Steady state: clk_out period = 2·(cur_div+1) clk_in cycles.
- Ramp step spacing = ramp_period+1 cycles.
- Full ramp from DIV_MAX to tgt = (DIV_MAX−tgt)·(ramp_period+1) cycles ±1.
- at_speed and state are registered and change on the edge of the transition.
- Stop always completes with clk_out=0; the last toggle before IDLE is falling.

## Test plan
- Bench overrides DIV_MIN=4, DIV_MAX=20 for all scenarios below.
- Reset: assert reset mid-RUN → clk_out=0, cur_div=20, state=IDLE, tick=0 immediately.
- Start: ramp_period=0, target_div=4, run=1 → cur_div 20→4, one step per cycle, 16 steps. state=RUN after step 16. Half-period then 5 cycles.
- Clamp: target_div=1 → cur_div settles at 4. target_div=4000 → settles at 20.
- Retarget at speed: RUN at 4, target_div=10, ramp_period=3 → cur_div +1 every 4 cycles to 10, then RUN. at_speed low during slew.
- Stop: run=0 in RUN at 4 → DECEL, ramps to 20, IDLE entered on a falling clk_out toggle, counters 0.
- Reversal: dir_in toggled in RUN → DECEL to 20, 1 IDLE cycle, SLEW with dir_out=new dir. run re-asserted mid-DECEL with same dir → SLEW without IDLE.
